canvas_grid_ctrl: RTL and testbench
===================================

CANVAS_GRID_CTRL -- requirements
Module: canvas_grid_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 14, grid columns.
REQ-002 SHALL have parameter GRID_H, default 14, grid rows.
REQ-003 SHALL have parameter CELL, default 10, cell edge in pixels.
REQ-004 SHALL have parameter X0, default 89, and Y0, default 33, canvas top-left pixel.
REQ-005 SHALL have parameter INK, default 15'h7FFF, paint colour; BG, default 15'h0000, erase colour.
REQ-006 SHALL have port CLOCK_50  in  1  single clock, all logic on rising edge.
REQ-007 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports mouse_x, mouse_y  in  9 each  cursor pixel position.
REQ-009 SHALL have ports left_click, right_click  in  1 each  paint / erase level requests.
REQ-010 SHALL have port clear_req  in  1  one-cycle pulse, wipe whole canvas.
REQ-011 SHALL have port rd_addr  in  $clog2(GRID_W*GRID_H)  cell index, row*GRID_W+col.
REQ-012 SHALL have port rd_data  out  1  bitmap bit at rd_addr.
REQ-013 SHALL have ports vga_x, vga_y  out  9 each; vga_color  out  15; vga_plot  out  1  pixel write strobe.
REQ-014 SHALL have ports busy  out  1  FSM not IDLE; done  out  1  one-cycle pulse at end of paint/erase/clear.

Function
REQ-015 SHALL hold a GRID_W*GRID_H-bit bitmap, 1 = inked cell.
REQ-016 FSM states: IDLE, MAP, CHECK, FILL, CLEAR, FIN.
REQ-017 IDLE: clear_req (or latched pending clear) -> CLEAR; else left_click or right_click with cursor inside canvas -> MAP, capturing mouse_x, mouse_y and mode (left wins if both asserted).
REQ-018 Inside canvas means X0 <= x < X0+GRID_W*CELL and Y0 <= y < Y0+GRID_H*CELL; outside -> stay IDLE, no plot.
REQ-019 MAP: col, row from repeated subtraction of CELL, one subtraction per axis per cycle, both axes in parallel; exits when both remainders < CELL (max max(GRID_W,GRID_H) cycles).
REQ-020 CHECK (1 cycle): if bitmap bit already equals target (1 paint, 0 erase) -> IDLE with no plot and no done; else update bit -> FILL.
REQ-021 FILL: raster-scan CELL*CELL pixels of the cell, one per cycle, x inner; vga_plot=1, vga_color=INK or BG; then FIN.
REQ-022 CLEAR: raster-scan all GRID_W*CELL x GRID_H*CELL canvas pixels with BG, one per cycle; bitmap zeroed on entry; then FIN.
REQ-023 FIN: done=1 for exactly one cycle -> IDLE.
REQ-024 clear_req arriving in any non-IDLE state SHALL be latched and served from the next IDLE; a second pulse while pending is merged.
REQ-025 Mouse and click inputs SHALL be ignored while busy; held click repaints nothing (REQ-020).
REQ-026 rd_data SHALL be combinational from bitmap; rd_addr >= GRID_W*GRID_H returns 0.
REQ-027 vga_x/vga_y SHALL be absolute screen coordinates, valid only when vga_plot=1.

Reset
REQ-028 resetn low SHALL force IDLE, bitmap all 0, pending clear 0, vga_plot 0, busy 0, done 0, vga_x/vga_y/vga_color 0, regardless of in-progress FILL/CLEAR.
REQ-029 First state action SHALL occur on the first rising edge after resetn deasserts.

Configuration
REQ-030 Macro CANVAS_READOUT_EN: defined -> rd_addr/rd_data per REQ-026; undefined -> rd_data tied 0, rd_addr unused, bitmap still drives REQ-020.

Verification
REQ-031 Reset, left_click at (89,33) -> 100 plots x=89..98, y=33..42, INK, done pulse, rd_data[0]=1.
REQ-032 left_click held at (229,229)... no: (228,172) -> cell row 13 col 13, addr 195 set; held further 50 cycles -> no further plots.
REQ-033 Cursor (88,100) or (229,100) clicked -> no plot, busy stays 0.
REQ-034 Paint addr 0, then right_click at (95,40) -> 100 BG plots, rd_data[0]=0; right_click again -> no plots.
REQ-035 clear_req pulsed mid-FILL -> FILL completes, done, then 19600 BG plots, done, all rd_data 0.
REQ-036 resetn asserted mid-CLEAR -> vga_plot 0 immediately, busy 0, bitmap 0; next click behaves as REQ-031.

Source files
------------

// File: rtl/canvas_grid_ctrl.sv
// rtl/canvas_grid_ctrl.sv - cell-grid paint/erase/clear controller driving a pixel plotter.
// Optional bitmap readout port enabled by CANVAS_READOUT_EN.
module canvas_grid_ctrl #(
  parameter int          GRID_W = 14,
  parameter int          GRID_H = 14,
  parameter int          CELL   = 10,
  parameter int          X0     = 89,
  parameter int          Y0     = 33,
  parameter logic [14:0] INK    = 15'h7FFF,
  parameter logic [14:0] BG     = 15'h0000
) (
  input  logic                             CLOCK_50,
  input  logic                             resetn,
  input  logic [8:0]                       mouse_x,
  input  logic [8:0]                       mouse_y,
  input  logic                             left_click,
  input  logic                             right_click,
  input  logic                             clear_req,
  input  logic [$clog2(GRID_W*GRID_H)-1:0] rd_addr,
  output logic                             rd_data,
  output logic [8:0]                       vga_x,
  output logic [8:0]                       vga_y,
  output logic [14:0]                      vga_color,
  output logic                             vga_plot,
  output logic                             busy,
  output logic                             done
);
  localparam int N  = GRID_W * GRID_H;
  localparam int AW = $clog2(N);

  localparam logic [9:0] X_LO    = 10'(X0);
  localparam logic [9:0] X_HI    = 10'(X0 + GRID_W * CELL);
  localparam logic [9:0] Y_LO    = 10'(Y0);
  localparam logic [9:0] Y_HI    = 10'(Y0 + GRID_H * CELL);
  localparam logic [8:0] X0_9    = 9'(X0);
  localparam logic [8:0] Y0_9    = 9'(Y0);
  localparam logic [8:0] CELL_9  = 9'(CELL);
  localparam logic [8:0] CELL_M1 = 9'(CELL - 1);
  localparam logic [8:0] CW_M1   = 9'(GRID_W * CELL - 1);
  localparam logic [8:0] CH_M1   = 9'(GRID_H * CELL - 1);

  typedef enum logic [2:0] {IDLE, MAP, CHECK, FILL, CLEAR, FIN} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  bitmap;
  logic          pend_clr;
  logic          mode;
  logic [8:0]    cap_x, cap_y;
  logic [8:0]    rem_x, rem_y;
  logic [8:0]    base_x, base_y;
  logic [8:0]    px, py;
  logic [AW-1:0] col, row, idx;
  logic          click, in_canvas, map_done, cur_bit;
  logic [8:0]    x_last, y_last;
  logic          x_end, scan_end;

  assign click     = left_click | right_click;
  assign in_canvas = ({1'b0, mouse_x} >= X_LO) && ({1'b0, mouse_x} < X_HI) &&
                     ({1'b0, mouse_y} >= Y_LO) && ({1'b0, mouse_y} < Y_HI);
  assign map_done  = (rem_x < CELL_9) && (rem_y < CELL_9);
  assign idx       = AW'(row * GRID_W) + col;
  assign cur_bit   = bitmap[idx];

  // Same raster counter serves both a single cell and the whole canvas.
  assign x_last   = (state == CLEAR) ? CW_M1 : CELL_M1;
  assign y_last   = (state == CLEAR) ? CH_M1 : CELL_M1;
  assign x_end    = (px == x_last);
  assign scan_end = x_end && (py == y_last);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    vga_plot  = 1'b0;
    vga_x     = '0;
    vga_y     = '0;
    vga_color = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req || pend_clr)   state_nxt = CLEAR;
        else if (click && in_canvas) state_nxt = MAP;
      end
      MAP:   if (map_done) state_nxt = CHECK;
      CHECK: state_nxt = (cur_bit == mode) ? IDLE : FILL;
      FILL: begin
        vga_plot  = 1'b1;
        vga_x     = base_x + px;
        vga_y     = base_y + py;
        vga_color = mode ? INK : BG;
        if (scan_end) state_nxt = FIN;
      end
      CLEAR: begin
        vga_plot  = 1'b1;
        vga_x     = base_x + px;
        vga_y     = base_y + py;
        vga_color = BG;
        if (scan_end) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bitmap   <= '0;
      pend_clr <= 1'b0;
      mode     <= 1'b0;
      cap_x    <= '0;
      cap_y    <= '0;
      rem_x    <= '0;
      rem_y    <= '0;
      base_x   <= '0;
      base_y   <= '0;
      px       <= '0;
      py       <= '0;
      col      <= '0;
      row      <= '0;
    end else begin
      if (clear_req && (state != IDLE)) pend_clr <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_req || pend_clr) begin
            bitmap   <= '0;
            pend_clr <= 1'b0;
            base_x   <= X0_9;
            base_y   <= Y0_9;
            px       <= '0;
            py       <= '0;
          end else if (click && in_canvas) begin
            cap_x <= mouse_x;
            cap_y <= mouse_y;
            rem_x <= mouse_x - X0_9;
            rem_y <= mouse_y - Y0_9;
            col   <= '0;
            row   <= '0;
            mode  <= left_click;
          end
        end
        MAP: begin
          if (rem_x >= CELL_9) begin
            rem_x <= rem_x - CELL_9;
            col   <= col + 1'b1;
          end
          if (rem_y >= CELL_9) begin
            rem_y <= rem_y - CELL_9;
            row   <= row + 1'b1;
          end
        end
        CHECK: begin
          // Cell origin is the cursor minus its in-cell remainder.
          if (cur_bit != mode) begin
            bitmap[idx] <= mode;
            base_x      <= cap_x - rem_x;
            base_y      <= cap_y - rem_y;
            px          <= '0;
            py          <= '0;
          end
        end
        FILL, CLEAR: begin
          if (x_end) begin
            px <= '0;
            py <= py + 1'b1;
          end else begin
            px <= px + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CANVAS_READOUT_EN
  localparam logic [AW:0] N_EXT = (AW + 1)'(N);
  assign rd_data = ({1'b0, rd_addr} < N_EXT) ? bitmap[rd_addr] : 1'b0;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 1'b0;
`endif

endmodule

// File: tb/tb_canvas_grid_ctrl.sv
// tb/tb_canvas_grid_ctrl.sv - scoreboard bench for canvas_grid_ctrl.
module tb_canvas_grid_ctrl;
  localparam int CELL = 10;
  localparam int X0   = 89;
  localparam int Y0   = 33;
  localparam int N    = 196;
  localparam logic [14:0] INK = 15'h7FFF;
  localparam logic [14:0] BG  = 15'h0000;

  logic        CLOCK_50 = 1'b0;
  logic        resetn   = 1'b0;
  logic [8:0]  mouse_x  = '0;
  logic [8:0]  mouse_y  = '0;
  logic        left_click  = 1'b0;
  logic        right_click = 1'b0;
  logic        clear_req   = 1'b0;
  logic [7:0]  rd_addr     = '0;
  logic        rd_data;
  logic [8:0]  vga_x, vga_y;
  logic [14:0] vga_color;
  logic        vga_plot, busy, done;

  always #10 CLOCK_50 = ~CLOCK_50;

  canvas_grid_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .left_click (left_click),
    .right_click(right_click),
    .clear_req  (clear_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  int          n_pass   = 0;
  int          n_total  = 0;
  int          plot_cnt = 0;
  int          done_cnt = 0;
  logic [32:0] exp_q[$];
  logic        model[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  always @(negedge CLOCK_50) begin
    if (done) done_cnt++;
    if (vga_plot) begin
      plot_cnt++;
      n_total++;
      assert (exp_q.size() > 0) n_pass++;
      else $error("FAIL extra_plot observed x=%0d y=%0d expected no plot", vga_x, vga_y);
      if (exp_q.size() > 0)
        check("plot", 64'({vga_x, vga_y, vga_color}), 64'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic push_cell(input int c, input int r, input logic [14:0] colr);
    for (int y = 0; y < CELL; y++)
      for (int x = 0; x < CELL; x++)
        exp_q.push_back({9'(X0 + c * CELL + x), 9'(Y0 + r * CELL + y), colr});
  endtask

  task automatic push_clear();
    for (int y = 0; y < 140; y++)
      for (int x = 0; x < 140; x++)
        exp_q.push_back({9'(X0 + x), 9'(Y0 + y), BG});
  endtask

  task automatic click(input int x, input int y, input logic l, input logic r, input int hold);
    mouse_x     = 9'(x);
    mouse_y     = 9'(y);
    left_click  = l;
    right_click = r;
    tick(hold);
    left_click  = 1'b0;
    right_click = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (!busy && exp_q.size() == 0) break;
      tick(1);
    end
    n_total++;
    assert (k < budget) n_pass++;
    else $error("FAIL timeout observed=%0d cycles expected<%0d pending=%0d", k, budget, exp_q.size());
    tick(4);
  endtask

  task automatic check_rd(input int a, input string tag);
    logic expv;
    rd_addr = 8'(a);
    #1;
`ifdef CANVAS_READOUT_EN
    expv = (a < N) ? model[a] : 1'b0;
`else
    expv = 1'b0;
`endif
    check(tag, 64'(rd_data), 64'(expv));
  endtask

  task automatic check_op(input string tag, input int p0, input int d0, input int np, input int nd);
    check({tag, "_plots"}, 64'(plot_cnt - p0), 64'(np));
    check({tag, "_done"},  64'(done_cnt - d0), 64'(nd));
  endtask

  initial begin
    int   p0, d0;
    logic saw;
    int   pts[4][2];
    for (int i = 0; i < N; i++) model[i] = 1'b0;

    tick(3);
    check("rst_plot",  64'(vga_plot),  64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_x",     64'(vga_x),     64'(0));
    check("rst_y",     64'(vga_y),     64'(0));
    check("rst_color", 64'(vga_color), 64'(0));
    check_rd(0, "rst_rd0");
    resetn = 1'b1;
    tick(2);

    // First cell paint at the canvas origin.
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(0, 0, INK); model[0] = 1'b1;
    click(89, 33, 1'b1, 1'b0, 2);
    wait_idle(400);
    check_op("paint0", p0, d0, 100, 1);
    check_rd(0, "paint0_rd");

    // Far corner, click held well past completion.
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(13, 13, INK); model[195] = 1'b1;
    click(228, 172, 1'b1, 1'b0, 200);
    wait_idle(400);
    check_op("corner", p0, d0, 100, 1);
    check_rd(195, "corner_rd");
    check_rd(194, "corner_rd_nb");

    // Just outside each canvas edge.
    pts = '{'{88, 100}, '{229, 100}, '{150, 32}, '{150, 173}};
    p0 = plot_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      saw = 1'b0;
      mouse_x = 9'(pts[i][0]);
      mouse_y = 9'(pts[i][1]);
      left_click  = (i % 2 == 0);
      right_click = (i % 2 == 1);
      for (int c = 0; c < 4; c++) begin
        tick(1);
        saw = saw | busy;
      end
      left_click = 1'b0; right_click = 1'b0;
      check("outside_busy", 64'(saw), 64'(0));
    end
    check_op("outside", p0, d0, 0, 0);

    // Erase cell 0, then erase again (already clear).
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(0, 0, BG); model[0] = 1'b0;
    click(95, 40, 1'b0, 1'b1, 2);
    wait_idle(400);
    check_op("erase", p0, d0, 100, 1);
    check_rd(0, "erase_rd");
    p0 = plot_cnt; d0 = done_cnt;
    click(95, 40, 1'b0, 1'b1, 5);
    wait_idle(400);
    check_op("erase_again", p0, d0, 0, 0);

    // Both buttons: left wins, interior cell (6,6).
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(6, 6, INK); model[90] = 1'b1;
    click(150, 100, 1'b1, 1'b1, 2);
    wait_idle(400);
    check_op("both", p0, d0, 100, 1);
    check_rd(90, "both_rd");

    // Clear requested twice during a fill: one merged clear follows.
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(3, 2, INK); model[31] = 1'b1;
    click(120, 60, 1'b1, 1'b0, 2);
    tick(30);
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    push_clear();
    for (int i = 0; i < N; i++) model[i] = 1'b0;
    tick(10);
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    wait_idle(25000);
    tick(20);
    check_op("clear", p0, d0, 19700, 2);
    check("clear_idle", 64'(busy), 64'(0));
    check_rd(0, "clear_rd0");
    check_rd(31, "clear_rd31");
    check_rd(90, "clear_rd90");
    check_rd(195, "clear_rd195");
    check_rd(200, "rd_oob");

    // Reset mid-fill with a clear pending.
    push_cell(6, 6, INK);
    click(150, 100, 1'b1, 1'b0, 2);
    tick(20);
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    tick(20);
    resetn = 1'b0;
    #1;
    check("rstfill_plot", 64'(vga_plot), 64'(0));
    check("rstfill_busy", 64'(busy),     64'(0));
    exp_q.delete();
    tick(2);
    resetn = 1'b1;
    p0 = plot_cnt; d0 = done_cnt;
    tick(20);
    check_op("no_pend", p0, d0, 0, 0);
    check_rd(90, "rstfill_rd");
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(6, 6, INK); model[90] = 1'b1;
    click(150, 100, 1'b1, 1'b0, 2);
    wait_idle(400);
    check_op("repaint", p0, d0, 100, 1);

    // Reset mid-clear, then the origin paint again.
    clear_req = 1'b1; tick(1); clear_req = 1'b0;
    push_clear();
    for (int i = 0; i < N; i++) model[i] = 1'b0;
    tick(300);
    check("clr_active", 64'(vga_plot), 64'(1));
    resetn = 1'b0;
    #1;
    check("rstclr_plot",  64'(vga_plot),  64'(0));
    check("rstclr_busy",  64'(busy),      64'(0));
    check("rstclr_x",     64'(vga_x),     64'(0));
    check("rstclr_y",     64'(vga_y),     64'(0));
    check("rstclr_color", 64'(vga_color), 64'(0));
    exp_q.delete();
    tick(2);
    resetn = 1'b1;
    tick(2);
    check_rd(90, "rstclr_rd");
    p0 = plot_cnt; d0 = done_cnt;
    push_cell(0, 0, INK); model[0] = 1'b1;
    click(89, 33, 1'b1, 1'b0, 2);
    wait_idle(400);
    check_op("post_rst", p0, d0, 100, 1);
    check_rd(0, "post_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
